// File: rtl/keypad_emulator.sv
// keypad_emulator: passive 4x4 keypad model that answers an active-low row scan with
// active-low columns, including LFSR-driven contact bounce on press and release
module keypad_emulator #(
  parameter int         BOUNCE_CYCLES = 8,
  parameter int         GAP_CYCLES    = 16,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, PRESS, HELD, REL, GAP} state_t;
  localparam logic [7:0]  LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] B_LOAD    = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] G_LOAD    = 16'(GAP_CYCLES - 1);
  // nibble k holds {row,col} of hex key k
  localparam logic [63:0] KEY_MAP   = 64'hFB73_ECA9_8654_210D;
  state_t      r_state;
  logic [3:0]  r_key;
  logic [15:0] r_hold;
  logic [15:0] r_cnt;
  logic [7:0]  r_lfsr;
  logic        r_done;
  logic        w_bounce;
  logic        w_last;
  logic        w_contact;
  logic        w_hit;
  logic [3:0]  w_map;
  assign w_bounce  = (r_state == PRESS) || (r_state == REL);
  assign w_last    = r_cnt == 16'd0;
  assign w_contact = (r_state == HELD) || (w_bounce && r_lfsr[0]);
  assign w_map     = KEY_MAP[{r_key, 2'b00} +: 4];
  assign w_hit     = w_contact && !rows[w_map[3:2]];
  assign cols      = ~(4'(w_hit) << w_map[1:0]);
  assign cmd_ready = r_state == IDLE;
  assign busy      = ~cmd_ready;
  assign done      = r_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= 4'h0;
      r_hold  <= 16'd0;
      r_cnt   <= 16'd0;
      r_lfsr  <= LFSR_INIT;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == GAP) && w_last;
      if (w_bounce) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_state <= PRESS;
          r_key   <= cmd_key;
          r_hold  <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
          r_cnt   <= B_LOAD;
        end
        PRESS: begin
          r_state <= w_last ? HELD : PRESS;
          r_cnt   <= w_last ? r_hold - 16'd1 : r_cnt - 16'd1;
        end
        HELD: begin
          r_state <= w_last ? REL : HELD;
          r_cnt   <= w_last ? B_LOAD : r_cnt - 16'd1;
        end
        REL: begin
          r_state <= w_last ? GAP : REL;
          r_cnt   <= w_last ? G_LOAD : r_cnt - 16'd1;
        end
        GAP: begin
          r_state <= w_last ? IDLE : GAP;
          r_cnt   <= w_last ? 16'd0 : r_cnt - 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
